// File: rtl/neighbor_mem_arbiter.sv
// neighbor_mem_arbiter
//   Round-robin arbiter that multiplexes N_REQ requesters onto a single
//   shared memory port. A grant is held while the owner keeps req high. If
//   it is held for MAX_HOLD cycles while another requester waits, the grant
//   is revoked and the owner is told so through a one-cycle preempt pulse.
//   Every grant is followed by one HANDOFF cycle before the next
//   arbitration.
//
// Ports
//   clock, nrst          rising-edge clock, synchronous active-low reset
//   req[N_REQ]           per-requester access request (level)
//   addr_i, wr_en_i,     packed requester address / write enable / write
//   wdata_i              data, port k at [k*W +: W]
//   gnt[N_REQ]           registered one-hot grant
//   gnt_id[2]            index of the granted port (meaningful while busy)
//   busy                 a grant is currently held
//   preempt[N_REQ]       one-cycle pulse on the port whose grant was revoked
//   mem_addr, mem_wr_en, shared memory port, driven by the granted requester
//   mem_wdata
//   mem_rdata            memory read data (combinational from mem_addr)
//   rdata_o              mem_rdata broadcast to every requester
module neighbor_mem_arbiter #(
  parameter int          N_REQ    = 3,
  parameter int          AW       = 16,
  parameter int          DW       = 16,
  parameter logic [15:0] MAX_HOLD = 16'd256
) (
  input  logic                clock,
  input  logic                nrst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr_i,
  input  logic [N_REQ-1:0]    wr_en_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
  output logic [N_REQ-1:0]    gnt,
  output logic [1:0]          gnt_id,
  output logic                busy,
  output logic [N_REQ-1:0]    preempt,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_wr_en,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic [DW-1:0]       rdata_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  last_gnt;
  logic [15:0] hold_cnt;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;

  // Unpacked views padded to four entries so a 2-bit gnt_id always
  // indexes a defined element whatever N_REQ is.
  logic [AW-1:0] addr_arr  [4];
  logic [DW-1:0] wdata_arr [4];
  logic [3:0]    wr_pad;
  logic [3:0]    req_pad;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_unpack
      if (k < N_REQ) begin : g_used
        assign addr_arr[k]  = addr_i[k*AW +: AW];
        assign wdata_arr[k] = wdata_i[k*DW +: DW];
        assign wr_pad[k]    = wr_en_i[k];
        assign req_pad[k]   = req[k];
      end else begin : g_unused
        assign addr_arr[k]  = '0;
        assign wdata_arr[k] = '0;
        assign wr_pad[k]    = 1'b0;
        assign req_pad[k]   = 1'b0;
      end
    end
  endgenerate

  // Round-robin search starting one past the most recent owner.
  logic [1:0]       winner;
  logic             found;
  logic [N_REQ-1:0] win_onehot;
  logic             others_waiting;

  always_comb begin
    int cand;
    winner = 2'd0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_gnt) + i) % N_REQ;
      if (!found && req_pad[cand[1:0]]) begin
        winner = cand[1:0];
        found  = 1'b1;
      end
    end
    win_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      win_onehot[j] = (winner == 2'(j));
    end
  end

  assign others_waiting = |(req & ~gnt);

  // The memory port follows the owner live; between grants it replays the
  // last values driven, and write enable is forced low.
  assign mem_addr  = busy ? addr_arr[gnt_id]  : addr_hold;
  assign mem_wdata = busy ? wdata_arr[gnt_id] : wdata_hold;
  assign mem_wr_en = busy & wr_pad[gnt_id];
  assign rdata_o   = mem_rdata;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= 2'd0;
      busy       <= 1'b0;
      preempt    <= '0;
      hold_cnt   <= 16'd0;
      last_gnt   <= 2'(N_REQ - 1);
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      preempt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= win_onehot;
            gnt_id   <= winner;
            busy     <= 1'b1;
            hold_cnt <= 16'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          addr_hold  <= addr_arr[gnt_id];
          wdata_hold <= wdata_arr[gnt_id];
          if (!req_pad[gnt_id]) begin
            gnt      <= '0;
            busy     <= 1'b0;
            last_gnt <= gnt_id;
            state    <= HANDOFF;
          end else if (MAX_HOLD != 16'd0 && hold_cnt == MAX_HOLD &&
                       others_waiting) begin
            // Owner still wants the port but has used up its slice.
            gnt      <= '0;
            busy     <= 1'b0;
            preempt  <= gnt;
            last_gnt <= gnt_id;
            state    <= HANDOFF;
          end else if (hold_cnt != MAX_HOLD) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        HANDOFF: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_mem_arbiter.sv
module tb_neighbor_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            nrst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_i;
  logic [N-1:0]    wr_en_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic [N-1:0]    preempt;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   rdata_o;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Simple memory: read data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  neighbor_mem_arbiter #(
    .N_REQ(N), .AW(AW), .DW(DW), .MAX_HOLD(16'd4)
  ) dut (
    .clock(clock), .nrst(nrst), .req(req), .addr_i(addr_i),
    .wr_en_i(wr_en_i), .wdata_i(wdata_i), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .preempt(preempt), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rdata_o(rdata_o)
  );

  // One-hot grant monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (nrst === 1'b1) begin
      checks++;
      if ($countones(gnt) > 1) begin
        failures++;
        $display("FAIL onehot gnt=%b expected at most one bit", gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = '0; wr_en_i = '0; addr_i = '0; wdata_i = '0;
    tick(); tick();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || preempt !== 3'b000 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctrl gnt=%b busy=%b preempt=%b gnt_id=%0d expected 000/0/000/0",
               gnt, busy, preempt, gnt_id);
    end
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_mem wr=%b addr=%h wdata=%h expected 0/0000/0000",
               mem_wr_en, mem_addr, mem_wdata);
    end
    nrst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_order [3];
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    req = 3'b111;
    for (int g = 0; g < 3; g++) begin
      if (g > 0) begin
        // HANDOFF then IDLE: two cycles without a grant.
        for (int c = 0; c < 2; c++) begin
          tick();
          checks++;
          if (gnt !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_gap%0d_%0d gnt=%b busy=%b expected 000/0", g, c, gnt, busy);
          end
        end
      end
      tick();
      checks++;
      if (gnt !== exp_order[g] || busy !== 1'b1 || gnt_id !== 2'(g)) begin
        failures++;
        $display("FAIL rr_grant%0d gnt=%b busy=%b id=%0d expected %b/1/%0d",
                 g, gnt, busy, gnt_id, exp_order[g], g);
      end
      req[g] = 1'b0;
    end
    tick(); tick(); tick();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle gnt=%b busy=%b expected 000/0", gnt, busy);
    end
  endtask

  task automatic test_write_mux();
    addr_i = '0; wdata_i = '0;
    addr_i[0 +: AW]  = 16'h1111; wdata_i[0 +: DW]  = 16'hAAAA;
    addr_i[AW +: AW] = 16'h00C8; wdata_i[DW +: DW] = 16'h0005;
    wr_en_i = 3'b011;
    req = 3'b010;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle mem_wr_en=%b expected 0", mem_wr_en);
    end
    tick();
    checks++;
    if (gnt !== 3'b010 || mem_addr !== 16'h00C8 || mem_wr_en !== 1'b1 || mem_wdata !== 16'h0005) begin
      failures++;
      $display("FAIL wr_port1 gnt=%b addr=%h wr=%b wdata=%h expected 010/00c8/1/0005",
               gnt, mem_addr, mem_wr_en, mem_wdata);
    end
    checks++;
    if (rdata_o !== (16'h00C8 ^ 16'hA5A5)) begin
      failures++;
      $display("FAIL rdata rdata_o=%h expected %h", rdata_o, 16'h00C8 ^ 16'hA5A5);
    end
    addr_i[AW +: AW] = 16'h00C9;
    #1;
    checks++;
    if (mem_addr !== 16'h00C9) begin
      failures++;
      $display("FAIL wr_follow addr=%h expected 00c9", mem_addr);
    end
    req = 3'b000;
    tick();
    addr_i[AW +: AW] = 16'h00FF;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 16'h00C9 || mem_wdata !== 16'h0005 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_hold wr=%b addr=%h wdata=%h busy=%b expected 0/00c9/0005/0",
               mem_wr_en, mem_addr, mem_wdata, busy);
    end
    wr_en_i = '0;
    tick();
  endtask

  task automatic test_preempt();
    req = 3'b001;
    tick();
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("FAIL pre_grant gnt=%b expected 001", gnt);
    end
    req = 3'b101;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt !== 3'b001 || preempt !== 3'b000) begin
        failures++;
        $display("FAIL pre_hold%0d gnt=%b preempt=%b expected 001/000", c, gnt, preempt);
      end
    end
    tick();
    checks++;
    if (gnt !== 3'b000 || preempt !== 3'b001 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pre_pulse gnt=%b preempt=%b busy=%b expected 000/001/0", gnt, preempt, busy);
    end
    tick();
    checks++;
    if (gnt !== 3'b000 || preempt !== 3'b000) begin
      failures++;
      $display("FAIL pre_after gnt=%b preempt=%b expected 000/000", gnt, preempt);
    end
    tick();
    checks++;
    if (gnt !== 3'b100) begin
      failures++;
      $display("FAIL pre_next gnt=%b expected 100", gnt);
    end
    req = 3'b001;
    tick(); tick(); tick();
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("FAIL pre_return gnt=%b expected 001", gnt);
    end
    req = 3'b000;
    tick(); tick(); tick();
  endtask

  task automatic test_no_preempt();
    req = 3'b001;
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (gnt !== 3'b001 || preempt !== 3'b000) begin
        failures++;
        $display("FAIL solo_hold%0d gnt=%b preempt=%b expected 001/000", c, gnt, preempt);
      end
      tick();
    end
    req = 3'b000;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    addr_i[2*AW +: AW]  = 16'h0ABC;
    wdata_i[2*DW +: DW] = 16'h1234;
    wr_en_i = 3'b100;
    req = 3'b100;
    tick();
    checks++;
    if (gnt !== 3'b100 || mem_wr_en !== 1'b1 || mem_addr !== 16'h0ABC) begin
      failures++;
      $display("FAIL rst_write gnt=%b wr=%b addr=%h expected 100/1/0abc", gnt, mem_wr_en, mem_addr);
    end
    tick();
    nrst = 1'b0;
    tick();
    checks++;
    if (gnt !== 3'b000 || mem_wr_en !== 1'b0 || mem_addr !== 16'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid gnt=%b wr=%b addr=%h busy=%b expected 000/0/0000/0",
               gnt, mem_wr_en, mem_addr, busy);
    end
    nrst = 1'b1;
    tick();
    checks++;
    if (gnt !== 3'b100 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL rst_regrant gnt=%b id=%0d expected 100/2", gnt, gnt_id);
    end
    req = 3'b000; wr_en_i = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_pulse();
    req = 3'b010;
    tick();
    checks++;
    if (gnt !== 3'b010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pulse_grant gnt=%b id=%0d busy=%b expected 010/1/1", gnt, gnt_id, busy);
    end
    req = 3'b000;
    tick();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pulse_handoff gnt=%b busy=%b expected 000/0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pulse_idle gnt=%b busy=%b expected 000/0", gnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_mux();
    test_preempt();
    test_no_preempt();
    test_reset_mid_grant();
    test_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neighbor_mem_arbiter.md
NEIGHBOR_MEM_ARBITER -- requirements
Module: neighbor_mem_arbiter

Interface
REQ-001 Parameters: N_REQ, default 3, number of requester ports (2..4).
REQ-002 Parameters: AW, default 16, address width; DW, default 16, word width.
REQ-003 Parameters: MAX_HOLD, default 16'd256, grant-hold limit in cycles; 0 disables preemption.
REQ-004 Ports: clock input 1, rising-edge system clock.
REQ-005 Ports: nrst input 1, reset, synchronous, active-low.
REQ-006 Ports: req input N_REQ, per-requester access request, level.
REQ-007 Ports: addr_i input N_REQ*AW, packed requester addresses, port k at bits [k*AW +: AW].
REQ-008 Ports: wr_en_i input N_REQ, per-requester write enable.
REQ-009 Ports: wdata_i input N_REQ*DW, packed requester write data.
REQ-010 Ports: gnt output N_REQ, registered one-hot grant.
REQ-011 Ports: gnt_id output 2, index of granted port, valid only while busy=1.
REQ-012 Ports: busy output 1, high while any grant is held.
REQ-013 Ports: preempt output N_REQ, one-cycle pulse on the port whose grant is forcibly revoked.
REQ-014 Ports: mem_addr output AW, mem_wr_en output 1, mem_wdata output DW, shared memory port.
REQ-015 Ports: mem_rdata input DW, memory read data, combinational from mem_addr.
REQ-016 Ports: rdata_o output DW, mem_rdata broadcast to all requesters.

Function
REQ-017 FSM states SHALL be IDLE, GRANT and HANDOFF.
REQ-018 IDLE: any req bit sampled high SHALL select the winner round-robin, starting at (last_gnt+1) mod N_REQ; next edge sets gnt[winner], busy=1, enters GRANT.
REQ-019 Latency from req rising to gnt high SHALL be exactly 1 cycle when the arbiter is in IDLE.
REQ-020 GRANT: mem_addr, mem_wr_en, mem_wdata SHALL combinationally follow the granted port's addr_i, wr_en_i, wdata_i.
REQ-021 mem_wr_en SHALL be 0 whenever busy=0, regardless of wr_en_i.
REQ-022 Outside GRANT, mem_addr and mem_wdata SHALL hold their last driven values.
REQ-023 rdata_o SHALL equal mem_rdata in every cycle; only the granted requester may consume it.
REQ-024 GRANT, req[g] sampled low: next edge clears gnt, busy=0, last_gnt=g, enters HANDOFF.
REQ-025 HANDOFF SHALL last exactly one cycle with no grant, then go to IDLE; minimum gap between consecutive grants is 2 cycles.
REQ-026 Hold counter SHALL clear on grant, increment each GRANT cycle, and saturate at MAX_HOLD.
REQ-027 Counter == MAX_HOLD, MAX_HOLD != 0, any other req bit high: next edge revokes grant, pulses preempt[g] for one cycle, last_gnt=g, enters HANDOFF.
REQ-028 Counter at MAX_HOLD with no other requester pending: grant SHALL be kept and counter held saturated.
REQ-029 A preempted requester still asserting req SHALL re-enter arbitration and be served only after the others per round-robin.
REQ-030 Requester deasserting req in the same cycle gnt rises: grant SHALL last exactly one cycle, then release per REQ-024.
REQ-031 req changes on non-granted ports during GRANT SHALL have no effect until IDLE.
REQ-032 gnt SHALL never have more than one bit set.

Reset
REQ-033 nrst low at a rising edge SHALL force state IDLE, gnt=0, preempt=0, busy=0, gnt_id=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, hold counter=0, last_gnt=N_REQ-1 (port 0 wins first).
REQ-034 Reset mid-grant SHALL drop the grant and mem_wr_en on that edge with no trailing write.

Verification
REQ-035 After reset, req=3'b111 -> gnt=3'b001 one cycle later; sequential releases yield grant order 0,1,2, each separated by one HANDOFF cycle.
REQ-036 Port 1 granted, addr_i[1]=16'h0C8, wr_en_i[1]=1, wdata_i[1]=16'h0005 -> mem_addr=16'h0C8, mem_wr_en=1, mem_wdata=16'h0005; port 0 wr_en_i=1 ungranted never reaches mem_wr_en.
REQ-037 MAX_HOLD=4, port 0 holds req, port 2 requests -> after 4 GRANT cycles preempt[0] pulses once, HANDOFF, then gnt=3'b100.
REQ-038 MAX_HOLD=4, only port 0 requesting for 20 cycles -> gnt stays 3'b001, preempt stays 0.
REQ-039 nrst asserted while port 2 writes (mem_wr_en=1) -> next cycle gnt=0, mem_wr_en=0, mem_addr=0; after release req=3'b100 -> gnt=3'b100 one cycle later.
REQ-040 req[1] one-cycle pulse in IDLE -> gnt=3'b010 exactly one cycle, then HANDOFF, then IDLE with busy=0.
